// File: rtl/reg_mem_arbiter.sv
`timescale 1ns/1ps
// reg_mem_arbiter
// Shares a single downstream memory port between REQ_NUM requesters
// (snapshot-memory or register-native-interface bridges). Round-robin grant,
// one transaction in flight, per-transaction timeout, rejection of
// commands that are not exactly one of read/write.
//
// Ports
//   clk, soft_rst        clock, synchronous active-high reset
//   req_vld/req_addr/req_wr_en/req_rd_en/req_wr_data
//                        per-requester request, slice i of a packed bus at [i*W +: W]
//   ack_vld/err          one-hot completion pulse and its error qualifier
//   rd_data              shared read data, valid with any ack_vld bit
//   mem_req_vld/mem_addr/mem_wr_en/mem_rd_en/mem_wr_data
//                        downstream request, held until mem_ack_vld
//   mem_ack_vld/mem_err/mem_rd_data
//                        downstream completion
// All outputs are registered.
module reg_mem_arbiter #(
  parameter int REQ_NUM        = 2,
  parameter int MEM_DATA_WIDTH = 64,
  parameter int MEM_ADDR_WIDTH = 5,
  parameter int TIMEOUT        = 255
) (
  input  logic                                clk,
  input  logic                                soft_rst,
  input  logic [REQ_NUM-1:0]                  req_vld,
  input  logic [REQ_NUM*MEM_ADDR_WIDTH-1:0]   req_addr,
  input  logic [REQ_NUM-1:0]                  req_wr_en,
  input  logic [REQ_NUM-1:0]                  req_rd_en,
  input  logic [REQ_NUM*MEM_DATA_WIDTH-1:0]   req_wr_data,
  output logic [REQ_NUM-1:0]                  ack_vld,
  output logic [REQ_NUM-1:0]                  err,
  output logic [MEM_DATA_WIDTH-1:0]           rd_data,
  output logic                                mem_req_vld,
  input  logic                                mem_ack_vld,
  input  logic                                mem_err,
  output logic [MEM_ADDR_WIDTH-1:0]           mem_addr,
  output logic                                mem_wr_en,
  output logic                                mem_rd_en,
  output logic [MEM_DATA_WIDTH-1:0]           mem_wr_data,
  input  logic [MEM_DATA_WIDTH-1:0]           mem_rd_data
);

  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]           grant_q, grant_d;
  logic [15:0]                timer_q, timer_d;
  logic                       mem_req_vld_q, mem_req_vld_d;
  logic [MEM_ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                       mem_wr_en_q, mem_wr_en_d;
  logic                       mem_rd_en_q, mem_rd_en_d;
  logic [MEM_DATA_WIDTH-1:0]  mem_wr_data_q, mem_wr_data_d;
  logic [REQ_NUM-1:0]         ack_vld_q, ack_vld_d;
  logic [REQ_NUM-1:0]         err_q, err_d;
  logic [MEM_DATA_WIDTH-1:0]  rd_data_q, rd_data_d;

  logic             any_req;
  logic             found;
  logic [IDX_W-1:0] sel;
  logic             legal;
  logic             tmo_hit;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % REQ_NUM);
  endfunction

  // Round-robin search starting just after the last grant.
  always_comb begin
    any_req = |req_vld;
    found   = 1'b0;
    sel     = '0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      if (!found && req_vld[wrap_idx(int'(rr_ptr_q) + k)]) begin
        found = 1'b1;
        sel   = wrap_idx(int'(rr_ptr_q) + k);
      end
    end
  end

  // Exactly one of write/read is a legal command.
  assign legal   = req_wr_en[sel] ^ req_rd_en[sel];
  assign tmo_hit = (timer_q == TMO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (soft_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = legal ? S_BUSY : S_DONE;
      S_BUSY:  if (mem_ack_vld || tmo_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    timer_d       = timer_q;
    mem_req_vld_d = mem_req_vld_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_en_d   = mem_wr_en_q;
    mem_rd_en_d   = mem_rd_en_q;
    mem_wr_data_d = mem_wr_data_q;
    ack_vld_d     = '0;            // completion is a single-cycle pulse
    err_d         = '0;
    rd_data_d     = rd_data_q;     // rd_data holds until the next completion
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (any_req) begin
          grant_d  = sel;
          rr_ptr_d = sel;
          if (legal) begin
            mem_req_vld_d = 1'b1;
            mem_addr_d    = req_addr[sel*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
            mem_wr_en_d   = req_wr_en[sel];
            mem_rd_en_d   = req_rd_en[sel];
            mem_wr_data_d = req_wr_data[sel*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
          end else begin
            ack_vld_d[sel] = 1'b1;
            err_d[sel]     = 1'b1;
            rd_data_d      = '0;
          end
        end
      end
      S_BUSY: begin
        if (mem_ack_vld || tmo_hit) begin
          // A real ack wins over a simultaneous expiry.
          mem_req_vld_d      = 1'b0;
          mem_addr_d         = '0;
          mem_wr_en_d        = 1'b0;
          mem_rd_en_d        = 1'b0;
          mem_wr_data_d      = '0;
          timer_d            = '0;
          ack_vld_d[grant_q] = 1'b1;
          err_d[grant_q]     = mem_ack_vld ? mem_err : 1'b1;
          rd_data_d          = mem_ack_vld ? mem_rd_data : '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      rr_ptr_q      <= IDX_W'(REQ_NUM - 1);
      grant_q       <= '0;
      timer_q       <= '0;
      mem_req_vld_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_data_q <= '0;
      ack_vld_q     <= '0;
      err_q         <= '0;
      rd_data_q     <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      timer_q       <= timer_d;
      mem_req_vld_q <= mem_req_vld_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_data_q <= mem_wr_data_d;
      ack_vld_q     <= ack_vld_d;
      err_q         <= err_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign ack_vld     = ack_vld_q;
  assign err         = err_q;
  assign rd_data     = rd_data_q;
  assign mem_req_vld = mem_req_vld_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_data = mem_wr_data_q;

endmodule
